// File: rtl/acc_pkg.sv
// -----------------------------------------------------------------------------
// acc_pkg
// Shared definitions for the shift-and-add multiplier accumulator register:
//   - ACC_W_DEFAULT : default operand width
//   - ACC_REG_W     : register width at the default operand width (2*W+1)
//   - acc_op_t      : register operation, decoded from Load/Ad/Sh
//   - acc_decode()  : priority decode of the three command levels
//   - acc_cnt_w()   : width of the optional shift counter for a given W
// -----------------------------------------------------------------------------
package acc_pkg;

  localparam int ACC_W_DEFAULT = 16;
  localparam int ACC_REG_W     = 2 * ACC_W_DEFAULT + 1;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_LOAD,
    OP_ADD,
    OP_SHIFT,
    OP_ADD_SHIFT
  } acc_op_t;

  // Load dominates; otherwise Ad and Sh combine into add, shift or add+shift.
  function automatic acc_op_t acc_decode(input logic load, input logic ad,
                                         input logic sh);
    if (load)           return OP_LOAD;
    else if (ad && sh)  return OP_ADD_SHIFT;
    else if (ad)        return OP_ADD;
    else if (sh)        return OP_SHIFT;
    else                return OP_HOLD;
  endfunction

  // Enough bits to hold the value W itself (the saturation point).
  function automatic int acc_cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/acc_if.sv
// -----------------------------------------------------------------------------
// acc_if
// Command/data bundle between the multiplier control FSM (master) and the
// accumulator register (slave).
//   Entradas [2W:0] : {adder sum incl. carry, multiplier operand}
//   Load            : initialise register with the multiplier
//   Ad              : capture adder sum into the upper slice
//   Sh              : logical shift right by one
//   Saidas   [2W:0] : register contents (Saidas[0] = current multiplier bit)
//   Cnt, Done       : shift count / count reached W (only with
//                     ACC_SHIFT_COUNT_EN defined)
// -----------------------------------------------------------------------------
interface acc_if
  import acc_pkg::*;
#(
  parameter int W = ACC_W_DEFAULT
) ();

  logic [2*W:0]            Entradas;
  logic                    Load;
  logic                    Ad;
  logic                    Sh;
  logic [2*W:0]            Saidas;
`ifdef ACC_SHIFT_COUNT_EN
  logic [acc_cnt_w(W)-1:0] Cnt;
  logic                    Done;
`endif

  modport master (
    output Entradas, Load, Ad, Sh,
    input  Saidas
`ifdef ACC_SHIFT_COUNT_EN
    , input Cnt, Done
`endif
  );

  modport slave (
    input  Entradas, Load, Ad, Sh,
    output Saidas
`ifdef ACC_SHIFT_COUNT_EN
    , output Cnt, Done
`endif
  );

endinterface

// File: rtl/acc_shift_cnt.sv
// -----------------------------------------------------------------------------
// acc_shift_cnt
// Saturating count of shifts since the last Load or reset, plus a registered
// Done flag that is high exactly while the count equals W.
//   Clk    : rising-edge clock
//   Rst    : synchronous active-low reset
//   clr_i  : clear the count (Load)
//   sh_i   : a shift happens on this edge
//   cnt_o  : current count, 0..W
//   done_o : cnt_o == W
// -----------------------------------------------------------------------------
module acc_shift_cnt
  import acc_pkg::*;
#(
  parameter int W = ACC_W_DEFAULT
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    clr_i,
  input  logic                    sh_i,
  output logic [acc_cnt_w(W)-1:0] cnt_o,
  output logic                    done_o
);

  localparam int              CW      = acc_cnt_w(W);
  localparam logic [CW-1:0]   CNT_MAX = CW'(W);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (sh_i && (cnt_q != CNT_MAX))
      cnt_d = cnt_q + CW'(1);
    // Derive Done from the next count so it lines up with cnt_q.
    done_d = (cnt_d == CNT_MAX);
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign done_o = done_q;

endmodule

// File: rtl/acc.sv
// -----------------------------------------------------------------------------
// acc
// Accumulator/multiplier register of a sequential shift-and-add multiplier.
// Holds a 2W+1-bit word: {carry, partial product} in [2W:W], the multiplier
// (consumed LSB-first) in [W-1:0]. The sum is formed outside and presented on
// Entradas[2W:W]; this block only captures and shifts.
//   Clk : rising-edge clock
//   Rst : synchronous active-low reset
//   bus : acc_if.slave (Entradas, Load, Ad, Sh in; Saidas out;
//         Cnt, Done out when ACC_SHIFT_COUNT_EN is defined)
// Optional feature macro: ACC_SHIFT_COUNT_EN adds the saturating shift
// counter (acc_shift_cnt) and its Done flag.
// -----------------------------------------------------------------------------
module acc
  import acc_pkg::*;
#(
  parameter int W = ACC_W_DEFAULT
) (
  input  logic Clk,
  input  logic Rst,
  acc_if.slave bus
);

  localparam int RW = 2 * W + 1;

  acc_op_t       op;
  logic [RW-1:0] reg_q, reg_d;

  // NOTE: every output of this block gets a default first, so no path can
  // leave reg_d unassigned and infer a latch.
  always_comb begin
    op    = acc_decode(bus.Load, bus.Ad, bus.Sh);
    reg_d = reg_q;
    unique case (op)
      OP_LOAD:      reg_d = {{(W+1){1'b0}}, bus.Entradas[W-1:0]};
      OP_ADD:       reg_d[2*W:W] = bus.Entradas[2*W:W];
      OP_SHIFT:     reg_d = {1'b0, reg_q[2*W:1]};
      // The sum bypasses the register and is shifted in the same edge; the
      // multiplier bit just consumed (reg_q[0]) falls off the end.
      OP_ADD_SHIFT: reg_d = {1'b0, bus.Entradas[2*W:W], reg_q[W-1:1]};
      default:      ;
    endcase
  end

  // NOTE: reset is sampled on the clock edge only (synchronous), and state is
  // written with non-blocking assignments so all flops update together.
  always_ff @(posedge Clk) begin
    if (!Rst) reg_q <= '0;
    else      reg_q <= reg_d;
  end

  assign bus.Saidas = reg_q;

`ifdef ACC_SHIFT_COUNT_EN
  logic [acc_cnt_w(W)-1:0] cnt;
  logic                    done;

  // Load ignores Sh, so a Load edge never counts as a shift.
  acc_shift_cnt #(.W(W)) u_shift_cnt (
    .Clk    (Clk),
    .Rst    (Rst),
    .clr_i  (bus.Load),
    .sh_i   (bus.Sh),
    .cnt_o  (cnt),
    .done_o (done)
  );

  assign bus.Cnt  = cnt;
  assign bus.Done = done;
`endif

endmodule

// File: tb/tb_acc.sv
// -----------------------------------------------------------------------------
// tb_acc
// Self-checking bench for acc at W=16. A word-level model tracks the register
// using masks and shifts on the whole value and is compared against Saidas
// (and Cnt/Done when ACC_SHIFT_COUNT_EN is defined) on every falling edge.
// Directed vectors add literal expectations that pin the model.
// -----------------------------------------------------------------------------
module tb_acc;

  localparam int          W       = 16;
  localparam int          RW      = 2 * W + 1;
  localparam logic [32:0] E       = 33'h0_DC29_5BDB;
  localparam logic [32:0] LO_MASK = (33'd1 << W) - 33'd1;
  localparam logic [32:0] HI_MASK = ~LO_MASK;

  logic Clk = 1'b0;
  logic Rst;

  acc_if #(.W(W)) bus ();

  acc #(.W(W)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  logic [RW-1:0] m_val   = '0;
  int            m_cnt   = 0;
  logic          m_valid = 1'b0;

  always @(posedge Clk) begin
    if (!Rst) begin
      m_val   <= '0;
      m_cnt   <= 0;
      m_valid <= 1'b1;
    end else if (bus.Load) begin
      m_val <= bus.Entradas & LO_MASK;
      m_cnt <= 0;
    end else begin
      if (bus.Ad && bus.Sh)
        m_val <= ((bus.Entradas & HI_MASK) | (m_val & LO_MASK)) >> 1;
      else if (bus.Ad)
        m_val <= (bus.Entradas & HI_MASK) | (m_val & LO_MASK);
      else if (bus.Sh)
        m_val <= m_val >> 1;
      if (bus.Sh)
        m_cnt <= (m_cnt + 1 > W) ? W : m_cnt + 1;
    end
  end

  // ---------------------------------------------------------------- compare
  always @(negedge Clk) begin
    if (m_valid) begin
      check("saidas_vs_model", 64'(bus.Saidas), 64'(m_val));
`ifdef ACC_SHIFT_COUNT_EN
      check("cnt_vs_model",  64'(bus.Cnt),  64'(m_cnt));
      check("done_vs_model", 64'(bus.Done), 64'(m_cnt == W));
`endif
    end
  end

  // ---------------------------------------------------------------- stimulus
  // Drive one command level, then wait for the next falling edge so the
  // result of the intervening rising edge is visible.
  task automatic apply(input logic rst, input logic load, input logic ad,
                       input logic sh, input logic [RW-1:0] ent);
    Rst          = rst;
    bus.Load     = load;
    bus.Ad       = ad;
    bus.Sh       = sh;
    bus.Entradas = ent;
    @(negedge Clk);
  endtask

  // One multiplier step with the bench acting as the external adder.
  task automatic mul_step(input logic [W-1:0] a);
    logic [RW-1:0] sum;
    logic [RW-1:0] upper;
    upper = bus.Saidas >> W;
    sum   = (upper + RW'(a)) << W;
    if (bus.Saidas[0]) apply(1'b1, 1'b0, 1'b1, 1'b1, sum);
    else               apply(1'b1, 1'b0, 1'b0, 1'b1, sum);
  endtask

  task automatic mul_run(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int steps);
    apply(1'b1, 1'b1, 1'b0, 1'b0, RW'(b));
    for (int i = 0; i < steps; i++) mul_step(a);
  endtask

  initial begin
    // 1. reset dominates all commands
    apply(1'b0, 1'b1, 1'b1, 1'b1, E);
    check("reset_saidas", 64'(bus.Saidas), 64'h0);
`ifdef ACC_SHIFT_COUNT_EN
    check("reset_cnt",  64'(bus.Cnt),  64'h0);
    check("reset_done", 64'(bus.Done), 64'h0);
`endif

    // 2. load, alone and with Ad/Sh also high
    apply(1'b1, 1'b1, 1'b0, 1'b0, E);
    check("load", 64'(bus.Saidas), 64'h0_0000_5BDB);
    apply(1'b1, 1'b1, 1'b1, 1'b1, E);
    check("load_all_cmds", 64'(bus.Saidas), 64'h0_0000_5BDB);
    apply(1'b1, 1'b0, 1'b0, 1'b0, E);
    check("hold", 64'(bus.Saidas), 64'h0_0000_5BDB);

    // 3. add then shift on separate edges
    apply(1'b1, 1'b0, 1'b1, 1'b0, E);
    check("add", 64'(bus.Saidas), 64'h0_DC29_5BDB);
    apply(1'b1, 1'b0, 1'b0, 1'b1, E);
    check("shift_after_add", 64'(bus.Saidas), 64'h0_6E14_ADED);
    check("bit32_zero", 64'(bus.Saidas[32]), 64'h0);

    // 4. combined add+shift, and shift alone from load
    apply(1'b1, 1'b1, 1'b0, 1'b0, E);
    apply(1'b1, 1'b0, 1'b1, 1'b1, E);
    check("add_shift", 64'(bus.Saidas), 64'h0_6E14_ADED);
    apply(1'b1, 1'b1, 1'b0, 1'b0, E);
    apply(1'b1, 1'b0, 1'b0, 1'b1, E);
    check("shift_only", 64'(bus.Saidas), 64'h0_0000_2DED);

    // Level-sensitive: Sh held 3 cycles shifts 3 times
    apply(1'b1, 1'b1, 1'b0, 1'b0, E);
    for (int i = 0; i < 3; i++) apply(1'b1, 1'b0, 1'b0, 1'b1, E);
    check("shift_x3", 64'(bus.Saidas), 64'h0_0000_0B7B);

    // 5. full multiplies
    mul_run(16'd3, 16'd5, W);
    check("mul_3x5", 64'(bus.Saidas[31:0]), 64'd15);
`ifdef ACC_SHIFT_COUNT_EN
    check("mul_cnt_w",  64'(bus.Cnt),  64'd16);
    check("mul_done",   64'(bus.Done), 64'd1);
    apply(1'b1, 1'b0, 1'b0, 1'b1, '0);
    check("cnt_saturates", 64'(bus.Cnt), 64'd16);
`endif
    mul_run(16'hFFFF, 16'hFFFF, W);
    check("mul_ffff", 64'(bus.Saidas[31:0]), 64'hFFFE_0001);

    // Load mid-operation restarts cleanly
    mul_run(16'd7, 16'd9, 5);
    mul_run(16'd3, 16'd5, W);
    check("mul_restart_load", 64'(bus.Saidas[31:0]), 64'd15);

    // 6. reset after 7 shifts, then a fresh multiply
    mul_run(16'd3, 16'd5, 7);
    apply(1'b0, 1'b1, 1'b1, 1'b1, E);
    check("mid_reset", 64'(bus.Saidas), 64'h0);
`ifdef ACC_SHIFT_COUNT_EN
    check("mid_reset_cnt", 64'(bus.Cnt), 64'h0);
`endif
    mul_run(16'd3, 16'd5, W);
    check("mul_after_reset", 64'(bus.Saidas[31:0]), 64'd15);

    apply(1'b1, 1'b0, 1'b0, 1'b0, '0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
